// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART byte port between sources A and B.
// Optional stall timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_a_data,
  input  logic             i_a_valid,
  input  logic             i_a_last,
  output logic             o_a_ready,
  input  logic [7:0]       i_b_data,
  input  logic             i_b_valid,
  input  logic             i_b_last,
  output logic             o_b_ready,
  output logic [7:0]       o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [1:0]       o_grant,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_pkt_cnt_a,
  output logic [CNT_W-1:0] o_pkt_cnt_b,
  output logic             o_abort
);

  // Handshake: a byte moves on a rising edge where valid and ready are both high;
  // sources hold data/valid/last stable until accepted. o_busy exposes the FSM state.

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_served_q, last_served_d;  // 1 = B served last
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  logic sel_valid;
  logic sel_last;
  logic xfer;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES - 1);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               abort_q, abort_d;
`endif

  assign sel_valid = (grant_q[0] & i_a_valid) | (grant_q[1] & i_b_valid);
  assign sel_last  = (grant_q[0] & i_a_last)  | (grant_q[1] & i_b_last);
  assign xfer      = sel_valid & i_ready;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_served_d = last_served_q;
    cnt_a_d       = cnt_a_q;
    cnt_b_d       = cnt_b_q;
`ifdef UART_ARB_TIMEOUT_EN
    stall_d       = '0;
    abort_d       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // A wins when alone, or on contention when B was served last.
        if (i_a_valid && (!i_b_valid || last_served_q)) begin
          grant_d = 2'b01;
          state_d = ST_BUSY;
        end else if (i_b_valid) begin
          grant_d = 2'b10;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (xfer && sel_last) begin
          state_d       = ST_IDLE;
          grant_d       = 2'b00;
          last_served_d = grant_q[1];
          if (grant_q[0]) cnt_a_d = cnt_a_q + CNT_W'(1);
          if (grant_q[1]) cnt_b_d = cnt_b_q + CNT_W'(1);
        end
`ifdef UART_ARB_TIMEOUT_EN
        // Only an absent valid counts as a stall; backpressure keeps the counter clear.
        else if (!sel_valid) begin
          if (stall_q == STALL_LIMIT) begin
            state_d       = ST_IDLE;
            grant_d       = 2'b00;
            last_served_d = grant_q[1];
            abort_d       = 1'b1;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= 2'b00;
      last_served_q <= 1'b1;
      cnt_a_q       <= '0;
      cnt_b_q       <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      stall_q       <= '0;
      abort_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_served_q <= last_served_d;
      cnt_a_q       <= cnt_a_d;
      cnt_b_q       <= cnt_b_d;
`ifdef UART_ARB_TIMEOUT_EN
      stall_q       <= stall_d;
      abort_q       <= abort_d;
`endif
    end
  end

  assign o_data      = grant_q[0] ? i_a_data : (grant_q[1] ? i_b_data : 8'h00);
  assign o_valid     = sel_valid;
  assign o_a_ready   = grant_q[0] & i_ready;
  assign o_b_ready   = grant_q[1] & i_ready;
  assign o_grant     = grant_q;
  assign o_busy      = (state_q == ST_BUSY);
  assign o_pkt_cnt_a = cnt_a_q;
  assign o_pkt_cnt_b = cnt_b_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign o_abort     = abort_q;
`else
  assign o_abort     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: source drivers, a byte scoreboard keyed by grant,
// and cycle-exact checks of grant, counters, reset and (when enabled) timeout abort.
module tb_uart_tx_arbiter;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       a_data = 8'h00, b_data = 8'h00;
  logic             a_valid = 1'b0, a_last = 1'b0;
  logic             b_valid = 1'b0, b_last = 1'b0;
  logic             i_ready = 1'b1;
  logic             o_a_ready, o_b_ready, o_valid, o_busy, o_abort;
  logic [7:0]       o_data;
  logic [1:0]       o_grant;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  logic [9:0] exp_item;
  logic [7:0] msg_a[$];
  logic [7:0] msg_b[$];

  uart_tx_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_data(a_data), .i_a_valid(a_valid), .i_a_last(a_last), .o_a_ready(o_a_ready),
    .i_b_data(b_data), .i_b_valid(b_valid), .i_b_last(b_last), .o_b_ready(o_b_ready),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_grant(o_grant), .o_busy(o_busy),
    .o_pkt_cnt_a(cnt_a), .o_pkt_cnt_b(cnt_b), .o_abort(o_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted byte must match the next expected {grant, data}.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_byte", {22'd0, o_grant, o_data}, 32'hFFFF_FFFF);
      end else begin
        exp_item = exp_q.pop_front();
        chk("sb_byte", {22'd0, o_grant, o_data}, {22'd0, exp_item});
      end
    end
  end

  task automatic drive_a(input int budget);
    int waited = 0;
    while (msg_a.size() > 0) begin
      a_data  = msg_a[0];
      a_last  = (msg_a.size() == 1);
      a_valid = 1'b1;
      @(negedge clk);
      if (o_a_ready) begin
        void'(msg_a.pop_front());
      end else if (++waited > budget) begin
        chk("drv_a_timeout", 32'd1, 32'd0);
        msg_a.delete();
      end
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  task automatic drive_b(input int budget);
    int waited = 0;
    while (msg_b.size() > 0) begin
      b_data  = msg_b[0];
      b_last  = (msg_b.size() == 1);
      b_valid = 1'b1;
      @(negedge clk);
      if (o_b_ready) begin
        void'(msg_b.pop_front());
      end else if (++waited > budget) begin
        chk("drv_b_timeout", 32'd1, 32'd0);
        msg_b.delete();
      end
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    b_last  = 1'b0;
  endtask

  initial begin
    // Reset held with both sources valid: everything reads zero.
    a_data = 8'hAA; a_valid = 1'b1; b_data = 8'hBB; b_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_grant", {30'd0, o_grant}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_ready", {30'd0, o_a_ready, o_b_ready}, 32'd0);
    chk("rst_data", {24'd0, o_data}, 32'd0);
    chk("rst_cnts", {cnt_a, cnt_b}, 32'd0);
    chk("rst_abort", {31'd0, o_abort}, 32'd0);

    // A sends a 3-byte message right after release.
    @(posedge clk); #1;
    b_valid = 1'b0;
    a_valid = 1'b0;
    rst_n = 1'b1;
    msg_a = '{8'h41, 8'h42, 8'h43};
    exp_q.push_back({2'b01, 8'h41});
    exp_q.push_back({2'b01, 8'h42});
    exp_q.push_back({2'b01, 8'h43});
    fork
      drive_a(20);
      begin
        @(negedge clk);
        chk("arb_lat_c0_grant", {30'd0, o_grant}, 32'd0);
        chk("arb_lat_c0_valid", {31'd0, o_valid}, 32'd0);
        @(negedge clk);
        chk("arb_lat_c1_grant", {30'd0, o_grant}, 32'd1);
        chk("arb_lat_c1_valid", {31'd0, o_valid}, 32'd1);
      end
    join
    @(negedge clk);
    chk("msg3_idle", {30'd0, o_grant, o_busy}, 32'd0);
    chk("msg3_cnt_a", {16'd0, cnt_a}, 32'd1);

    // Fresh reset so last_served is B again, then two contention rounds.
    @(posedge clk); #1;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++) begin
      msg_a = '{8'hA0 + 8'(2 * r), 8'hA1 + 8'(2 * r)};
      msg_b = '{8'hB0 + 8'(2 * r), 8'hB1 + 8'(2 * r)};
      exp_q.push_back({2'b01, 8'hA0 + 8'(2 * r)});
      exp_q.push_back({2'b01, 8'hA1 + 8'(2 * r)});
      exp_q.push_back({2'b10, 8'hB0 + 8'(2 * r)});
      exp_q.push_back({2'b10, 8'hB1 + 8'(2 * r)});
      fork
        drive_a(40);
        drive_b(40);
        begin
          repeat (3) @(negedge clk);
          chk("cont_c2_grant", {30'd0, o_grant}, 32'd1);
          @(negedge clk);
          chk("cont_gap_grant", {30'd0, o_grant}, 32'd0);
          chk("cont_gap_valid", {31'd0, o_valid}, 32'd0);
          @(negedge clk);
          chk("cont_c4_grant", {30'd0, o_grant}, 32'd2);
        end
      join
    end
    @(negedge clk);
    chk("cont_cnt_a", {16'd0, cnt_a}, 32'd2);
    chk("cont_cnt_b", {16'd0, cnt_b}, 32'd2);
    @(posedge clk); #1;

    // B under backpressure, then a single-byte A message waiting behind it.
    msg_b = '{8'h55, 8'h66};
    msg_a = '{8'h0D};
    exp_q.push_back({2'b10, 8'h55});
    exp_q.push_back({2'b10, 8'h66});
    exp_q.push_back({2'b01, 8'h0D});
    fork
      drive_b(40);
      begin
        @(posedge clk); #1;
        drive_a(40);
      end
      begin
        for (int k = 0; k < 8; k++) begin
          i_ready = (k == 2 || k == 3) ? 1'b0 : 1'b1;
          @(negedge clk);
          if (k >= 1 && k <= 4) begin
            chk("bp_b_ready", {31'd0, o_b_ready}, {31'd0, i_ready});
            chk("bp_a_ready", {31'd0, o_a_ready}, 32'd0);
          end
          if (k == 6) chk("single_busy", {30'd0, o_grant, o_busy}, 32'h3);
          if (k == 7) chk("single_done", {31'd0, o_busy}, 32'd0);
          @(posedge clk); #1;
        end
        i_ready = 1'b1;
      end
    join
    chk("single_cnt_a", {16'd0, cnt_a}, 32'd3);
    chk("bp_cnt_b", {16'd0, cnt_b}, 32'd3);

`ifdef UART_ARB_TIMEOUT_EN
    // A stalls mid-message; after 8 stall cycles the grant is revoked and B gets the port.
    a_data = 8'h77; a_last = 1'b0; a_valid = 1'b1;
    exp_q.push_back({2'b01, 8'h77});
    exp_q.push_back({2'b10, 8'h99});
    fork
      begin
        @(posedge clk); #1;
        msg_b = '{8'h99};
        drive_b(50);
      end
      begin
        for (int k = 0; k < 13; k++) begin
          @(negedge clk);
          if (k == 1) chk("to_a_ready", {31'd0, o_a_ready}, 32'd1);
          if (k == 9) chk("to_c9", {30'd0, o_abort, o_busy}, 32'd1);
          if (k == 10) chk("to_abort", {29'd0, o_abort, o_busy, o_grant[0]}, 32'h4);
          if (k == 11) chk("to_after", {29'd0, o_abort, o_grant}, 32'd2);
          @(posedge clk); #1;
          if (k == 1) a_valid = 1'b0;
        end
      end
    join
    chk("to_cnt_a", {16'd0, cnt_a}, 32'd3);
    chk("to_cnt_b", {16'd0, cnt_b}, 32'd4);
`endif

    // Asynchronous reset while B is mid-message.
    b_data = 8'h11; b_last = 1'b0; b_valid = 1'b1;
    exp_q.push_back({2'b10, 8'h11});
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    b_data = 8'h22;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, o_valid}, 32'd0);
    chk("arst_grant", {29'd0, o_grant, o_busy}, 32'd0);
    chk("arst_ready_data", {22'd0, o_a_ready, o_b_ready, o_data}, 32'd0);
    chk("arst_cnts", {cnt_a, cnt_b}, 32'd0);
    b_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_no_regrant", {29'd0, o_grant, o_busy}, 32'd0);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-granular round-robin arbiter that shares the single `uart_wrapper` transmit byte port between two message sources, A and B. Example sources: the `control` status/echo path and a debug dump of Ethernet frames. It sits between the requesters and `uart_wrapper` (`i_data`/`i_valid`/`o_tx_ready`). A granted source keeps the port until its `last` byte is accepted, so messages never interleave on the serial line.

## Interface

Parameters:

- `TIMEOUT_CYCLES`, 50000: stall limit in clock cycles for a granted source, 1 ms at 50 MHz. Only used with `UART_ARB_TIMEOUT_EN`. Minimum legal value 2.
- `CNT_W`, 16: width of the per-source packet counters.

Ports:

- `i_clk`  in  1  system clock (50 MHz domain).
- `i_rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `i_a_data`  in  8  source A byte.
- `i_a_valid`  in  1  source A byte valid.
- `i_a_last`  in  1  source A byte is the final byte of its message.
- `o_a_ready`  out  1  source A byte accepted this cycle when `i_a_valid` is also high.
- `i_b_data`, `i_b_valid`, `i_b_last`, `o_b_ready`: same set of ports for source B.
- `o_data`  out  8  byte to `uart_wrapper.i_data`.
- `o_valid`  out  1  to `uart_wrapper.i_valid`.
- `i_ready`  in  1  from `uart_wrapper.o_tx_ready`.
- `o_grant`  out  2  one-hot current owner; bit0 = A, bit1 = B; 0 when idle.
- `o_busy`  out  1  high in BUSY.
- `o_pkt_cnt_a`, `o_pkt_cnt_b`  out  CNT_W  completed messages per source.
- `o_abort`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation

- Handshake on every interface: a byte transfers on a rising edge where valid and ready are both high. Sources hold data/valid/last stable until accepted.
- State machine, two states:
  - IDLE: all readies 0, `o_valid`=0, `o_grant`=0.
    - If exactly one source has valid high, grant that source.
    - If both have valid high, grant the source that is not `last_served`.
    - Next state is BUSY.
    - If no source has valid high, stay in IDLE.
  - BUSY: combinational pass-through from the granted source.
    - `o_data`/`o_valid` = the granted source's data/valid.
    - The granted source's ready = `i_ready`.
    - The non-granted source's ready = 0.
    - A transfer of a byte with `last` high → IDLE on the next edge. At the same edge: `last_served` := granted source, that source's packet counter +1 (wraps at 2^CNT_W), `o_grant` clears.
- `last_served` resets to B, so A wins the first contention.
- Message of length 1 (`last` on first byte) is legal; it completes in one BUSY cycle.
- Valid dropping mid-message does not release the grant (see Configuration).
- The non-granted source may assert valid at any time. It waits with ready=0 and no data loss.

## Timing

- Reset values, asynchronous, taking effect immediately on `i_rst_n` low:
  - State IDLE, `last_served`=B, `o_grant`=0, `o_busy`=0, `o_valid`=0.
  - `o_data`=0 in IDLE.
  - `o_a_ready`=`o_b_ready`=0, both counters 0, `o_abort`=0, timeout counter 0.
- Reset mid-message: the partial message is dropped. No byte is replayed after reset.
- Arbitration latency: 1 cycle from the first valid in IDLE to the first forwarded `o_valid`.
- In-message latency: 0 cycles, combinational.
- Gap between consecutive messages: exactly one IDLE cycle, including when the same source continues. Sustained throughput is therefore limited by UART speed, not by the arbiter.
- Counters and `o_grant` update on the same edge as the state transition.

## Configuration

- Macro `UART_ARB_TIMEOUT_EN`.
- Defined:
  - A stall counter runs in BUSY. It clears on any cycle where the granted valid=1 and increments while the granted valid=0.
  - When the counter reaches `TIMEOUT_CYCLES`-1 while valid is still 0, at the next edge:
    - state → IDLE, `o_abort` pulses for one cycle;
    - `last_served` := granted source;
    - the packet counter is not incremented.
  - Backpressure (`i_ready`=0 with valid=1) never counts as a stall.
- Undefined: no stall counter, `o_abort` tied 0, and a granted source holds the port indefinitely.

## Test plan

- Reset: hold `i_rst_n`=0 with both sources valid → all outputs 0. Release, A sends 3-byte message 0x41,0x42,0x43(last) with `i_ready`=1 → `o_grant`=01 from cycle 1; bytes appear on cycles 1–3; `o_pkt_cnt_a`=1; IDLE on cycle 4.
- Contention: A and B both present 2-byte messages in the same cycle, repeated twice → order A,B,A,B; one idle cycle between messages; counters end at 2/2.
- Backpressure: B sends 0x55,0x66(last) while `i_ready` toggles 1,0,0,1 → each byte is transferred exactly once, `o_b_ready` mirrors `i_ready`, A is never readied.
- Single-byte message: A sends 0x0D with last on its first byte → one BUSY cycle, `o_pkt_cnt_a` +1.
- Timeout (macro defined, `TIMEOUT_CYCLES`=8): A sends one byte without last, then valid=0 → `o_abort` pulses after 8 stall cycles, count_a is unchanged, and a pending B message is granted next.
- Async reset asserted while B is mid-message → outputs are zero immediately; after release, B is not granted unless its valid is still high.
